// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited requests to instruction memory, a two-entry
// {instr, pc} FIFO toward decode, and redirect flushes that discard in-flight responses.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid
);

   logic [31:0] fetchPc_q, fetchPc_d;
   logic [1:0]  outstanding_q, outstanding_d;
   logic [1:0]  discard_q, discard_d;
   logic [1:0]  count_q, count_d;
   logic        head_q, head_d;
   logic [31:0] lastPc_q, lastPc_d;
   logic [31:0] fifoInstr_q [2];
   logic [31:0] fifoPc_q [2];

   logic        respValid;
   logic        pushEn;
   logic        popEn;
   logic        tailIdx;
   logic [1:0]  liveOutstanding;
   logic [31:0] respPc;
   logic [2:0]  creditUse;
   logic [1:0]  unusedRedirectBits;

   assign unusedRedirectBits = redirect_pc[1:0];

   // Requests are sequential from fetchPc, and the surviving (non-discarded) ones are the
   // most recent, so the oldest live request sits liveOutstanding words behind fetchPc.
   always_comb begin
      respValid       = imem_rvalid && (outstanding_q != 2'd0);
      liveOutstanding = outstanding_q - discard_q;
      respPc          = fetchPc_q - {28'd0, liveOutstanding, 2'b00};
      instr_valid     = !rst && (count_q != 2'd0);
      popEn           = instr_valid && !stall && !redirect;
      pushEn          = respValid && (discard_q == 2'd0) && !redirect;
      tailIdx         = head_q ^ count_q[0];
      creditUse       = {1'b0, outstanding_q} + {1'b0, count_q} - {2'b00, popEn};
      imem_req        = !rst && !redirect && (creditUse < 3'd2);
      imem_addr       = {fetchPc_q[31:2], 2'b00};
      instr           = instr_valid ? fifoInstr_q[head_q] : NOP_INSTR;
      pc              = rst ? RESET_PC : (instr_valid ? fifoPc_q[head_q] : lastPc_q);
      pc_plus4        = pc + 32'd4;
   end

   // Next-state: a redirect flushes the FIFO and marks every still-unreturned request as stale.
   always_comb begin
      fetchPc_d     = fetchPc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      count_d       = count_q;
      head_d        = head_q;
      lastPc_d      = lastPc_q;
      if (respValid) begin
         outstanding_d = outstanding_q - 2'd1;
      end
      if (imem_req) begin
         outstanding_d = outstanding_d + 2'd1;
         fetchPc_d     = fetchPc_q + 32'd4;
      end
      if (redirect) begin
         fetchPc_d = {redirect_pc[31:2], 2'b00};
         discard_d = outstanding_d;
         count_d   = 2'd0;
         head_d    = 1'b0;
      end else begin
         if (respValid && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
         end
         count_d = count_q + {1'b0, pushEn} - {1'b0, popEn};
         if (popEn) begin
            head_d = ~head_q;
         end
      end
      if (instr_valid) begin
         lastPc_d = fifoPc_q[head_q];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetchPc_q     <= RESET_PC;
         outstanding_q <= 2'd0;
         discard_q     <= 2'd0;
         count_q       <= 2'd0;
         head_q        <= 1'b0;
         lastPc_q      <= RESET_PC;
      end else begin
         fetchPc_q     <= fetchPc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         head_q        <= head_d;
         lastPc_q      <= lastPc_d;
      end
   end

   // FIFO storage needs no reset; count_q alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!rst && pushEn) begin
         fifoInstr_q[tailIdx] <= imem_rdata;
         fifoPc_q[tailIdx]    <= respPc;
      end
   end

endmodule
